// File: rtl/sdram_rw_arbiter.sv
// Arbitrates SDRAM write/read bursts across CH_NUM FIFO channel pairs, each owning a
// circular region of 2^REG_W words. Writes have priority over reads; channels are served round-robin.
module sdram_rw_arbiter #(
    parameter  int CH_NUM      = 2,
    parameter  int CNT_W       = 10,
    parameter  int BURST_LEN   = 256,
    parameter  int RFIFO_DEPTH = 512,
    parameter  int REG_W       = 16,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int ADDR_W      = CH_W + REG_W
) (
    input  logic                    sclk,
    input  logic                    s_rst_n,
    input  logic [CH_NUM*CNT_W-1:0] wfifo_usedw,
    input  logic [CH_NUM*CNT_W-1:0] rfifo_usedw,
    input  logic                    cmd_done,
    output logic                    wr_trig,
    output logic                    rd_trig,
    output logic [CH_W-1:0]         trig_ch,
    output logic [ADDR_W-1:0]       trig_addr,
    output logic                    busy,
    output logic [CH_NUM-1:0]       rfifo_rd_ready,
    output logic [CH_NUM-1:0]       ovf
);

    localparam int NB     = (2 ** REG_W) / BURST_LEN;
    localparam int FILL_W = $clog2(NB + 1);

    // One extra bit so that limits equal to 2^CNT_W still compare correctly.
    localparam logic [CNT_W:0]    BURST_CMP  = (CNT_W + 1)'(BURST_LEN);
    localparam logic [CNT_W:0]    RD_LIMIT   = (CNT_W + 1)'(RFIFO_DEPTH - BURST_LEN);
    localparam logic [REG_W-1:0]  BURST_STEP = REG_W'(BURST_LEN);
    localparam logic [FILL_W-1:0] FILL_MAX   = FILL_W'(NB);

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    state_t              state, state_next;
    logic [REG_W-1:0]    wr_ptr [CH_NUM];
    logic [REG_W-1:0]    rd_ptr [CH_NUM];
    logic [FILL_W-1:0]   fill   [CH_NUM];
    logic [CH_W-1:0]     wr_rr, rd_rr;
    logic [CH_NUM-1:0]   wr_req, rd_req, rd_seen;
    logic [CH_W-1:0]     wr_pick, rd_pick, grant_ch, grant_ch_inc;
    logic                grant_wr, grant_rd;
    logic [ADDR_W-1:0]   grant_addr;

    // First requesting channel at or after start, wrapping around.
    function automatic logic [CH_W-1:0] rr_pick(input logic [CH_NUM-1:0] req,
                                                input logic [CH_W-1:0]   start);
        logic [CH_W-1:0] pick;
        int              idx;
        pick = start;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % CH_NUM;
            if (req[idx]) pick = CH_W'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        wr_req = '0;
        rd_req = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            wr_req[i] = {1'b0, wfifo_usedw[i*CNT_W +: CNT_W]} >= BURST_CMP;
            rd_req[i] = (fill[i] != '0) && ({1'b0, rfifo_usedw[i*CNT_W +: CNT_W]} <= RD_LIMIT);
        end
    end

    assign wr_pick = rr_pick(wr_req, wr_rr);
    assign rd_pick = rr_pick(rd_req, rd_rr);

    always_comb begin
        state_next = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        grant_ch   = '0;
        case (state)
            IDLE: begin
                if (|wr_req) begin
                    state_next = WR;
                    grant_wr   = 1'b1;
                    grant_ch   = wr_pick;
                end else if (|rd_req) begin
                    state_next = RD;
                    grant_rd   = 1'b1;
                    grant_ch   = rd_pick;
                end
            end
            WR, RD:  if (cmd_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign grant_addr   = {grant_ch, grant_wr ? wr_ptr[grant_ch] : rd_ptr[grant_ch]};
    assign grant_ch_inc = CH_W'((int'(grant_ch) + 1) % CH_NUM);

    always_ff @(posedge sclk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!s_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            wr_trig        <= 1'b0;
            rd_trig        <= 1'b0;
            busy           <= 1'b0;
            trig_ch        <= '0;
            trig_addr      <= '0;
            wr_rr          <= '0;
            rd_rr          <= '0;
            rd_seen        <= '0;
            rfifo_rd_ready <= '0;
            ovf            <= '0;
            // NOTE: these per-channel arrays are small flop banks, not RAM, so resetting them is cheap and required.
            for (int i = 0; i < CH_NUM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fill[i]   <= '0;
            end
        end else begin
            wr_trig <= grant_wr;
            rd_trig <= grant_rd;
            if (grant_wr || grant_rd) begin
                busy      <= 1'b1;
                trig_ch   <= grant_ch;
                trig_addr <= grant_addr;
            end
            if (grant_wr) wr_rr <= grant_ch_inc;
            if (grant_rd) rd_rr <= grant_ch_inc;

            if (state == WR && cmd_done) begin
                busy            <= 1'b0;
                wr_ptr[trig_ch] <= wr_ptr[trig_ch] + BURST_STEP;
                // A full region drops its oldest burst to make room.
                if (fill[trig_ch] == FILL_MAX) begin
                    rd_ptr[trig_ch] <= rd_ptr[trig_ch] + BURST_STEP;
                    ovf[trig_ch]    <= 1'b1;
                end else begin
                    fill[trig_ch] <= fill[trig_ch] + FILL_W'(1);
                end
            end

            if (state == RD && cmd_done) begin
                busy             <= 1'b0;
                rd_ptr[trig_ch]  <= rd_ptr[trig_ch] + BURST_STEP;
                fill[trig_ch]    <= fill[trig_ch] - FILL_W'(1);
                rd_seen[trig_ch] <= 1'b1;
            end

            for (int i = 0; i < CH_NUM; i++) begin
                if (rd_seen[i] && ({1'b0, rfifo_usedw[i*CNT_W +: CNT_W]} >= BURST_CMP))
                    rfifo_rd_ready[i] <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sdram_rw_arbiter.md
SDRAM_RW_ARBITER -- requirements
Module: sdram_rw_arbiter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- CH_NUM, 2: number of write/read FIFO channel pairs.
- CNT_W, 10: width of each FIFO used-word count.
- BURST_LEN, 256: words per SDRAM burst.
- RFIFO_DEPTH, 512: read-FIFO capacity in words.
- REG_W, 16: log2 of the per-channel SDRAM region size in words.
REQ-002 Derived widths SHALL be CH_W = max(1, clog2(CH_NUM)) and ADDR_W = CH_W + REG_W.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- sclk, in, 1: single clock.
- s_rst_n, in, 1: reset, synchronous, active-low.
- wfifo_usedw, in, CH_NUM*CNT_W: per-channel write-FIFO read-side count; channel i occupies bits [i*CNT_W +: CNT_W].
- rfifo_usedw, in, CH_NUM*CNT_W: per-channel read-FIFO write-side count.
- cmd_done, in, 1: controller has finished the current burst (one-cycle pulse).
- wr_trig, out, 1: one-cycle pulse that starts a write burst.
- rd_trig, out, 1: one-cycle pulse that starts a read burst.
- trig_ch, out, CH_W: channel of the current burst.
- trig_addr, out, ADDR_W: start word address {trig_ch, offset}.
- busy, out, 1: high while a burst is outstanding.
- rfifo_rd_ready, out, CH_NUM: per-channel sticky flag; downstream may read.
- ovf, out, CH_NUM: per-channel sticky flag; oldest data was overwritten.

Function
REQ-004 Per channel, the block SHALL keep wr_ptr and rd_ptr (REG_W bits each, burst-aligned) and fill, a count of bursts held in the region from 0 to NB, where NB = 2^REG_W / BURST_LEN.
REQ-005 Write request i SHALL be wfifo_usedw[i] >= BURST_LEN.
REQ-006 Read request i SHALL be fill[i] > 0 AND rfifo_usedw[i] <= RFIFO_DEPTH - BURST_LEN.
REQ-007 The FSM SHALL have states IDLE, WR, RD and reset to IDLE.
REQ-008 In IDLE, if any write request is present, the block SHALL grant a write (writes have strict priority over reads); otherwise, if any read request is present, it SHALL grant a read; otherwise it SHALL stay in IDLE.
REQ-009 Arbitration among channels SHALL be round-robin, with separate write and read pointers.
- The search starts at (last granted channel + 1) mod CH_NUM.
- Each pointer updates only when a grant is issued.
REQ-010 A grant decided in an IDLE cycle t SHALL, at cycle t+1:
- enter WR or RD;
- pulse wr_trig or rd_trig for exactly one cycle;
- set busy=1;
- load trig_ch and trig_addr = {ch, wr_ptr or rd_ptr}.
REQ-011 trig_ch and trig_addr SHALL hold stable from the trig cycle until cmd_done is sampled.
REQ-012 On cmd_done in WR or RD, the FSM SHALL return to IDLE on the next cycle with busy=0; the earliest next trig is two cycles after cmd_done.
REQ-013 cmd_done in IDLE SHALL be ignored.
REQ-014 On write completion:
- wr_ptr advances by BURST_LEN, wrapping modulo 2^REG_W.
- If fill < NB, fill increments.
- If fill == NB, fill stays at NB, rd_ptr advances by BURST_LEN (oldest burst dropped) and ovf[ch] sets.
REQ-015 On read completion, rd_ptr SHALL advance by BURST_LEN (with wrap) and fill SHALL decrement.
- A read grant only occurs with fill > 0, so fill never underflows.
REQ-016 rfifo_rd_ready[i] SHALL set once at least one read burst on channel i has completed and rfifo_usedw[i] >= BURST_LEN; it then stays set until reset.
REQ-017 Input counts SHALL be compared as unsigned values at CNT_W+1 bits, so that BURST_LEN and RFIFO_DEPTH values at the width boundary compare correctly.

Reset
REQ-018 While s_rst_n=0 at a sclk edge, the block SHALL:
- clear all pointers, fill counts and round-robin pointers;
- clear wr_trig, rd_trig, busy, trig_ch, trig_addr, rfifo_rd_ready and ovf;
- return the FSM to IDLE.
REQ-019 A reset asserted mid-burst SHALL abandon the burst; a cmd_done arriving after reset release SHALL be ignored.

Verification
REQ-020 With CH_NUM=2, set ch0 wfifo_usedw=256 at cycle t, then pulse cmd_done at t+5 -> wr_trig=1 at t+1 only, trig_addr=0, busy=0 at t+6, and ch0 fill=1.
REQ-021 Hold write requests on both channels and answer every burst with cmd_done -> grants alternate ch0, ch1, ch0, ...; ch0 trig_addr offsets run 0, 256, 512, ...
REQ-022 Hold a write request on ch1 and a read request on ch0 at the same time -> the write on ch1 is granted first, and the read on ch0 follows after cmd_done.
REQ-023 With REG_W=9 (NB=2), complete 3 write bursts on ch0 -> fill=2, ovf[0]=1, rd_ptr=256; the next read uses trig_addr offset 256.
REQ-024 Complete 1 read burst on ch0 with rfifo_usedw=255, then raise rfifo_usedw to 256 -> rfifo_rd_ready[0] rises one cycle later and stays 1 when usedw drops to 0.
REQ-025 Assert s_rst_n=0 between a rd_trig and its cmd_done -> all outputs are 0 on the next edge, and a late cmd_done causes no pointer change.
